axi_read_responder: RTL and testbench

- AXI read-side slave responder: accepts one read address (AR) at a time and returns arlen+1 data beats on R with correct rlast and rresp.
- Fetches each beat from a local single-cycle-latency memory port.
- Completes the protocol model opposite the write-side master FSM; this block is the slave end of the AR/R channels.
- Pairs with the write-channel FSM to close the read path in the AXI verification environment.

---
 rtl/axi_read_responder.sv | 170 +++++++++++++++++
 tb/tb_axi_read_responder.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_read_responder.sv
// rtl/axi_read_responder.sv - AXI read-channel slave: one AR burst at a time, beats fetched from a single-cycle memory port
module axi_read_responder #(
    parameter int AW = 32,
    parameter int DW = 64
) (
    input  logic          axi_aclk,
    input  logic          axi_areset,
    input  logic [AW-1:0] axi_araddr,
    input  logic [7:0]    axi_arlen,
    input  logic [2:0]    axi_arsize,
    input  logic [1:0]    axi_arburst,
    input  logic          axi_arvalid,
    output logic          axi_arready,
    output logic [DW-1:0] axi_rdata,
    output logic [1:0]    axi_rresp,
    output logic          axi_rlast,
    output logic          axi_rvalid,
    input  logic          axi_rready,
    output logic          mem_ren,
    output logic [AW-1:0] mem_raddr,
    input  logic [DW-1:0] mem_rdata
);

    localparam int         NB        = DW / 8;
    localparam logic [2:0] MAXSIZE   = 3'($clog2(NB));
    localparam logic [1:0] BURST_FIX = 2'b00;
    localparam logic [1:0] BURST_WRP = 2'b10;
    localparam logic [1:0] RESP_OKAY = 2'b00;
    localparam logic [1:0] RESP_SERR = 2'b10;

    typedef enum logic [1:0] {IDLE, FETCH, SEND} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [7:0]    len_q, len_d;
    logic [2:0]    size_q, size_d;
    logic [1:0]    burst_q, burst_d;
    logic          err_q, err_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          rvalid_q, rvalid_d;
    logic          rlast_q, rlast_d;
    logic [1:0]    rresp_q, rresp_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          first_q, first_d;

    logic          ar_err;
    logic          wrap_len_ok;
    logic [AW-1:0] step;
    logic [AW-1:0] aligned;
    logic [AW-1:0] incr_addr;
    logic [AW-1:0] wrap_span;
    logic [AW-1:0] wrap_lo;
    logic [AW-1:0] next_addr;

    assign wrap_len_ok = (axi_arlen == 8'd1) || (axi_arlen == 8'd3) ||
                         (axi_arlen == 8'd7) || (axi_arlen == 8'd15);
    assign ar_err      = (axi_arsize > MAXSIZE) || (axi_arburst == 2'b11) ||
                         ((axi_arburst == BURST_WRP) && !wrap_len_ok);

    assign step      = AW'(1) << size_q;
    assign aligned   = addr_q & ~(step - AW'(1));
    assign incr_addr = aligned + step;
    assign wrap_span = AW'({1'b0, len_q} + 9'd1) << size_q;
    assign wrap_lo   = addr_q & ~(wrap_span - AW'(1));

    always_comb begin
        next_addr = incr_addr;
        if (burst_q == BURST_FIX) begin
            next_addr = addr_q;
        end else if (burst_q == BURST_WRP) begin
            if (incr_addr == wrap_lo + wrap_span) begin
                next_addr = wrap_lo;
            end
        end
    end

    // Memory data is only valid in the first SEND cycle; it is captured there so later hold cycles stay stable.
    assign axi_rdata   = first_q ? (err_q ? '0 : mem_rdata) : rdata_q;
    assign axi_arready = (state_q == IDLE);
    assign axi_rvalid  = rvalid_q;
    assign axi_rlast   = rlast_q;
    assign axi_rresp   = rresp_q;
    assign mem_ren     = (state_q == FETCH) && !err_q;
    assign mem_raddr   = addr_q;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        len_d    = len_q;
        size_d   = size_q;
        burst_d  = burst_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        rvalid_d = rvalid_q;
        rlast_d  = rlast_q;
        rresp_d  = rresp_q;
        rdata_d  = rdata_q;
        first_d  = 1'b0;

        if (first_q) begin
            rdata_d = axi_rdata;
        end

        case (state_q)
            IDLE: begin
                if (axi_arvalid) begin
                    addr_d  = axi_araddr;
                    len_d   = axi_arlen;
                    size_d  = axi_arsize;
                    burst_d = axi_arburst;
                    err_d   = ar_err;
                    cnt_d   = 8'd0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                rvalid_d = 1'b1;
                rlast_d  = (cnt_q == len_q);
                rresp_d  = err_q ? RESP_SERR : RESP_OKAY;
                first_d  = 1'b1;
                state_d  = SEND;
            end
            SEND: begin
                if (rvalid_q && axi_rready) begin
                    rvalid_d = 1'b0;
                    rlast_d  = 1'b0;
                    if (rlast_q) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d   = cnt_q + 8'd1;
                        addr_d  = next_addr;
                        state_d = FETCH;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            len_q    <= '0;
            size_q   <= '0;
            burst_q  <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
            rresp_q  <= RESP_OKAY;
            rdata_q  <= '0;
            first_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            size_q   <= size_d;
            burst_q  <= burst_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            rvalid_q <= rvalid_d;
            rlast_q  <= rlast_d;
            rresp_q  <= rresp_d;
            rdata_q  <= rdata_d;
            first_q  <= first_d;
        end
    end

endmodule

// File: tb/tb_axi_read_responder.sv
// tb/tb_axi_read_responder.sv - scoreboard bench for axi_read_responder
module tb_axi_read_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] araddr = '0;
    logic [7:0]  arlen = '0;
    logic [2:0]  arsize = '0;
    logic [1:0]  arburst = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready = 1'b1;
    logic        mem_ren;
    logic [31:0] mem_raddr;
    logic [63:0] mem_rdata = '0;

    axi_read_responder #(.AW(32), .DW(64)) dut (
        .axi_aclk    (clk),
        .axi_areset  (rst),
        .axi_araddr  (araddr),
        .axi_arlen   (arlen),
        .axi_arsize  (arsize),
        .axi_arburst (arburst),
        .axi_arvalid (arvalid),
        .axi_arready (arready),
        .axi_rdata   (rdata),
        .axi_rresp   (rresp),
        .axi_rlast   (rlast),
        .axi_rvalid  (rvalid),
        .axi_rready  (rready),
        .mem_ren     (mem_ren),
        .mem_raddr   (mem_raddr),
        .mem_rdata   (mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    beat_t       exp_q[$];
    logic [31:0] addr_exp[$];
    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          last_edge = 0;
    logic        prev_rvalid = 1'b0;
    logic        hold_v = 1'b0;
    beat_t       hold_b;

    function automatic logic [63:0] memval(logic [31:0] a);
        return {~a, a};
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (mem_ren) mem_rdata <= memval(mem_raddr);
    end

    // Monitor: samples on the falling edge, the handshake it sees completes on the next rising edge.
    always @(negedge clk) begin
        if (rst) begin
            hold_v      = 1'b0;
            prev_rvalid = 1'b0;
        end else begin
            if (mem_ren) begin
                if (addr_exp.size() == 0) chk("mem_ren_unexpected", 64'd1, 64'd0);
                else                      chk("mem_raddr", {32'd0, mem_raddr}, {32'd0, addr_exp.pop_front()});
            end
            if (hold_v) begin
                chk("hold_rvalid", {63'd0, rvalid}, 64'd1);
                chk("hold_rdata", rdata, hold_b.data);
                chk("hold_rresp", {62'd0, rresp}, {62'd0, hold_b.resp});
                chk("hold_rlast", {63'd0, rlast}, {63'd0, hold_b.last});
            end
            hold_v = rvalid && !rready;
            hold_b = {rdata, rresp, rlast};
            if (rvalid && !prev_rvalid) chk("rvalid_latency", 64'(cyc + 1 - last_edge), 64'd2);
            prev_rvalid = rvalid;
            if (arvalid && arready) last_edge = cyc + 1;
            if (rvalid && rready) begin
                last_edge = cyc + 1;
                if (exp_q.size() == 0) begin
                    chk("extra_beat", 64'd1, 64'd0);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    chk("rdata", rdata, e.data);
                    chk("rresp", {62'd0, rresp}, {62'd0, e.resp});
                    chk("rlast", {63'd0, rlast}, {63'd0, e.last});
                end
            end
        end
    end

    task automatic push_beat(logic [31:0] a, logic err, logic last);
        beat_t b;
        b.data = err ? 64'd0 : memval(a);
        b.resp = err ? 2'b10 : 2'b00;
        b.last = last;
        exp_q.push_back(b);
        if (!err) addr_exp.push_back(a);
    endtask

    task automatic issue(logic [31:0] a, logic [7:0] len, logic [2:0] size, logic [1:0] burst);
        logic got;
        got = 1'b0;
        @(posedge clk); #1;
        araddr = a; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (arready) begin got = 1'b1; break; end
        end
        chk("ar_accept", {63'd0, got}, 64'd1);
        @(posedge clk); #1;
        arvalid = 1'b0;
    endtask

    task automatic wait_done();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && addr_exp.size() == 0 && arready && !rvalid) begin
                ok = 1'b1;
                break;
            end
        end
        chk("burst_done_arready", {63'd0, ok}, 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic got;
        repeat (3) @(negedge clk);
        chk("rst_arready", {63'd0, arready}, 64'd1);
        chk("rst_rvalid", {63'd0, rvalid}, 64'd0);
        chk("rst_rlast", {63'd0, rlast}, 64'd0);
        chk("rst_rresp", {62'd0, rresp}, 64'd0);
        chk("rst_rdata", rdata, 64'd0);
        chk("rst_mem_ren", {63'd0, mem_ren}, 64'd0);
        chk("rst_mem_raddr", {32'd0, mem_raddr}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // INCR 0x100, 4 x 8 bytes
        push_beat(32'h100, 1'b0, 1'b0);
        push_beat(32'h108, 1'b0, 1'b0);
        push_beat(32'h110, 1'b0, 1'b0);
        push_beat(32'h118, 1'b0, 1'b1);
        issue(32'h100, 8'd3, 3'd3, 2'b01);
        wait_done();

        // WRAP 0x1C, 4 x 4 bytes, wraps at 0x20 back to 0x10
        push_beat(32'h1C, 1'b0, 1'b0);
        push_beat(32'h10, 1'b0, 1'b0);
        push_beat(32'h14, 1'b0, 1'b0);
        push_beat(32'h18, 1'b0, 1'b1);
        issue(32'h1C, 8'd3, 3'd2, 2'b10);
        wait_done();

        // INCR unaligned start 0x103 size 2: first beat unaligned, then 0x104
        push_beat(32'h103, 1'b0, 1'b0);
        push_beat(32'h104, 1'b0, 1'b1);
        issue(32'h103, 8'd1, 3'd2, 2'b01);
        wait_done();

        // FIXED 0x40 with backpressure on beat 1
        rready = 1'b0;
        push_beat(32'h40, 1'b0, 1'b0);
        push_beat(32'h40, 1'b0, 1'b1);
        issue(32'h40, 8'd1, 3'd3, 2'b00);
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rvalid) begin got = 1'b1; break; end
        end
        chk("bp_rvalid_seen", {63'd0, got}, 64'd1);
        repeat (5) @(posedge clk);
        #1 rready = 1'b1;
        wait_done();

        // Error bursts: oversize, reserved burst type, illegal wrap length
        push_beat(32'h200, 1'b1, 1'b0);
        push_beat(32'h200, 1'b1, 1'b0);
        push_beat(32'h200, 1'b1, 1'b1);
        issue(32'h200, 8'd2, 3'd4, 2'b01);
        wait_done();
        push_beat(32'h300, 1'b1, 1'b0);
        push_beat(32'h300, 1'b1, 1'b1);
        issue(32'h300, 8'd1, 3'd3, 2'b11);
        wait_done();
        push_beat(32'h300, 1'b1, 1'b0);
        push_beat(32'h300, 1'b1, 1'b0);
        push_beat(32'h300, 1'b1, 1'b1);
        issue(32'h300, 8'd2, 3'd2, 2'b10);
        wait_done();

        // Reset in the middle of an 8-beat burst
        for (int i = 0; i < 8; i++) push_beat(32'h800 + 32'(i * 8), 1'b0, (i == 7));
        issue(32'h800, 8'd7, 3'd3, 2'b01);
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (mem_ren && mem_raddr == 32'h808) begin got = 1'b1; break; end
        end
        chk("mid_fetch_beat2", {63'd0, got}, 64'd1);
        @(posedge clk); #2;
        chk("pre_reset_rvalid", {63'd0, rvalid}, 64'd1);
        rst = 1'b1;
        #1;
        chk("async_rst_rvalid", {63'd0, rvalid}, 64'd0);
        chk("async_rst_arready", {63'd0, arready}, 64'd1);
        chk("async_rst_rlast", {63'd0, rlast}, 64'd0);
        exp_q.delete();
        addr_exp.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        push_beat(32'h900, 1'b0, 1'b1);
        issue(32'h900, 8'd0, 3'd3, 2'b01);
        wait_done();

        // arvalid held high: second address waits for the first burst to finish
        push_beat(32'hA00, 1'b0, 1'b0);
        push_beat(32'hA08, 1'b0, 1'b1);
        push_beat(32'hB00, 1'b0, 1'b1);
        @(posedge clk); #1;
        araddr = 32'hA00; arlen = 8'd1; arsize = 3'd3; arburst = 2'b01; arvalid = 1'b1;
        @(negedge clk);
        chk("held_first_arready", {63'd0, arready}, 64'd1);
        @(posedge clk); #1;
        araddr = 32'hB00; arlen = 8'd0;
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (arready) begin got = 1'b1; break; end
        end
        chk("held_second_accept", {63'd0, got}, 64'd1);
        chk("held_second_after_first", {63'd0, 31'd0, exp_q.size()}, 64'd1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        wait_done();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
